// File: rtl/cpu_sequencer.sv
// cpu_sequencer - eight-phase instruction sequencer for the 8-bit accumulator CPU.
//
// Walks a fixed eight-state cycle per instruction and decodes the memory
// strobes, IR/PC/accumulator enables and the sticky halt from the current
// state, the opcode in the IR and the ALU zero flag. Outputs are combinational
// from the registered state so every strobe is low while rst_n is asserted.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   opcode [2:0] in   opcode currently held in the IR (opcodes_t encoding)
//   zero         in   ALU zero flag, only looked at in ALU_OP
//   mem_rd       out  memory read strobe
//   mem_wr       out  memory write strobe
//   load_ir      out  instruction register load enable
//   inc_pc       out  program counter increment
//   load_pc      out  program counter load (jump)
//   load_ac      out  accumulator load from ALU output
//   halt         out  CPU halted (sticky until reset)
//   phase [3:0]  out  current state encoding, debug only
//   instr_count  out  retired-instruction count, CNT_W bits
//
// Build option: define SEQ_INSTR_COUNT_EN to get a saturating retired-
// instruction counter; otherwise instr_count is tied to zero.

module cpu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             load_ir,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_ac,
  output logic             halt,
  output logic [3:0]       phase,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
    XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
  } opcodes_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  state_t   state_r;
  state_t   next_state_s;
  opcodes_t op_s;
  logic     aluop_s;

  assign op_s    = opcodes_t'(opcode);
  // Instructions that read an operand and write the accumulator; STO is
  // deliberately excluded so mem_rd and mem_wr can never overlap.
  assign aluop_s = (op_s == ADD) || (op_s == AND) || (op_s == XOR) || (op_s == LDA);
  assign phase   = state_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INST_ADDR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: fixed ring, with HLT diverting into the absorbing HALTED state.
  always_comb begin
    next_state_s = INST_ADDR;
    case (state_r)
      INST_ADDR:  next_state_s = INST_FETCH;
      INST_FETCH: next_state_s = INST_LOAD;
      INST_LOAD:  next_state_s = IDLE;
      IDLE:       next_state_s = OP_ADDR;
      OP_ADDR: begin
        if (op_s == HLT) begin
          next_state_s = HALTED;
        end else begin
          next_state_s = OP_FETCH;
        end
      end
      OP_FETCH:   next_state_s = ALU_OP;
      ALU_OP:     next_state_s = STORE;
      STORE:      next_state_s = INST_ADDR;
      HALTED:     next_state_s = HALTED;
      default:    next_state_s = INST_ADDR;
    endcase
  end

  // Output decode from the registered state, current opcode and zero flag.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ac = 1'b0;
    halt    = 1'b0;
    case (state_r)
      INST_ADDR: begin
        mem_rd = 1'b0;
      end
      INST_FETCH: begin
        mem_rd = 1'b1;
      end
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        if (op_s == HLT) begin
          halt = 1'b1;
        end else begin
          inc_pc = 1'b1;
        end
      end
      OP_FETCH: begin
        mem_rd = aluop_s;
      end
      ALU_OP: begin
        mem_rd  = aluop_s;
        inc_pc  = (op_s == SKZ) && zero;
        load_pc = (op_s == JMP);
      end
      STORE: begin
        mem_rd  = aluop_s;
        load_ac = aluop_s;
        inc_pc  = (op_s == JMP);
        load_pc = (op_s == JMP);
        mem_wr  = (op_s == STO);
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        halt = 1'b0;
      end
    endcase
  end

`ifdef SEQ_INSTR_COUNT_EN
  logic [CNT_W-1:0] count_r;

  // Retired-instruction counter: bumps on STORE->INST_ADDR, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if ((state_r == STORE) && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign instr_count = count_r;
`else
  assign instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Stimulus tasks push the expected
// per-cycle outputs into a scoreboard queue as they drive opcode/zero on the
// falling edge; a monitor pops and compares shortly afterwards. Reset and
// halted-state behaviour that happens off the clock is checked inline.

module tb_cpu_sequencer;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       opcode;
  logic             zero;
  logic             mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt;
  logic [3:0]       phase;
  logic [CNT_W-1:0] instr_count;

  typedef struct packed {
    logic [3:0]       ph;
    logic [6:0]       st;   // {mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt}
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               bad   = 0;
  logic [CNT_W-1:0] exp_cnt;

  cpu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir), .inc_pc(inc_pc),
    .load_pc(load_pc), .load_ac(load_ac), .halt(halt), .phase(phase),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Reference strobes for one step (0..7) of a normal instruction cycle.
  function automatic logic [6:0] model(input int step, input logic [2:0] op, input logic z);
    logic a;
    logic rd, wr, ir, ipc, lpc, lac, h;
    a = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    {rd, wr, ir, ipc, lpc, lac, h} = 7'b0;
    if (step == 1) rd = 1'b1;
    if (step == 2 || step == 3) begin rd = 1'b1; ir = 1'b1; end
    if (step == 4) begin
      if (op == 3'd0) h = 1'b1;
      else ipc = 1'b1;
    end
    if (step == 5) rd = a;
    if (step == 6) begin rd = a; ipc = (op == 3'd1) && z; lpc = (op == 3'd7); end
    if (step == 7) begin
      rd = a; lac = a; ipc = (op == 3'd7); lpc = (op == 3'd7); wr = (op == 3'd6);
    end
    return {rd, wr, ir, ipc, lpc, lac, h};
  endfunction

  // Scoreboard monitor: compares each pushed expectation 2ns after the falling edge.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = {phase, mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt, instr_count};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle_outputs: got phase=%0d strobes=%b cnt=%0d, want phase=%0d strobes=%b cnt=%0d",
                 a.ph, a.st, a.cnt, e.ph, e.st, e.cnt);
      end
    end
  end

  function automatic void bump_count();
`ifdef SEQ_INSTR_COUNT_EN
    if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + CNT_W'(1);
`endif
  endfunction

  // Drive the first nsteps cycles of an instruction; zero only matters in ALU_OP.
  task automatic run_instr(input logic [2:0] op, input logic z_alu, input int nsteps);
    for (int step = 0; step < nsteps; step++) begin
      @(negedge clk);
      opcode = (step < 3) ? 3'($urandom_range(7)) : op;
      zero   = (step == 6) ? z_alu : 1'($urandom_range(1));
      sb.push_back({4'(step), model(step, opcode, zero), exp_cnt});
    end
    if (nsteps == 8 && op != 3'd0) bump_count();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({phase, mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt, instr_count} !== '0) begin
      bad++;
      $display("FAIL reset_state: got phase=%0d strobes=%b cnt=%0d, want all zero",
               phase, {mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt}, instr_count);
    end
    release_reset();
  endtask

  task automatic test_add();
    run_instr(3'd2, 1'b0, 8);
  endtask

  task automatic test_sto();
    run_instr(3'd6, 1'b1, 8);
  endtask

  task automatic test_skz();
    run_instr(3'd1, 1'b1, 8);
    run_instr(3'd1, 1'b0, 8);
  endtask

  task automatic test_jmp();
    run_instr(3'd7, 1'b1, 8);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_instr(3'($urandom_range(7, 1)), 1'($urandom_range(1)), 8);
    end
  endtask

  task automatic test_mid_reset();
    run_instr(3'd3, 1'b0, 7);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({phase, mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt, instr_count} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got phase=%0d strobes=%b cnt=%0d, want all zero",
               phase, {mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt}, instr_count);
    end
    exp_cnt = '0;
    release_reset();
    run_instr(3'd5, 1'b0, 8);
  endtask

  task automatic test_hlt();
    run_instr(3'd0, 1'b0, 5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = 3'($urandom_range(7));
      zero   = 1'($urandom_range(1));
      sb.push_back({4'd8, 7'b0000001, exp_cnt});
    end
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (phase !== 4'd0 || halt !== 1'b0 || instr_count !== '0) begin
      bad++;
      $display("FAIL halt_async_reset: got phase=%0d halt=%b cnt=%0d, want phase=0 halt=0 cnt=0",
               phase, halt, instr_count);
    end
    exp_cnt = '0;
    release_reset();
    run_instr(3'd4, 1'b1, 8);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sto();
    test_skz();
    test_jmp();
    test_back_to_back();
    test_mid_reset();
    test_hlt();
    repeat (2) @(negedge clk);
    #3;
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Eight-phase instruction sequencer for the 8-bit accumulator CPU.
- Drives memory read/write strobes, IR/PC/accumulator load enables and halt from the current opcode and the ALU zero flag.
- Sits upstream of alu_control: its load_ac and phase timing determine when the ALU result is captured.
- Opcode type is opcodes_t from package typedefs: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.

Parameters:
- CNT_W, 16, width of the retired-instruction counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; state advances on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  3 (opcodes_t)  opcode of the instruction currently in the IR.
- zero  input  1  ALU zero flag (accumulator == 0).
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- load_ir  output  1  instruction register load enable.
- inc_pc  output  1  program counter increment.
- load_pc  output  1  program counter load (jump).
- load_ac  output  1  accumulator load from ALU out.
- halt  output  1  CPU halted, sticky.
- phase  output  4  current state encoding, debug only.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. Asserting rst_n=0 forces state INST_ADDR immediately, at any point including mid-instruction. instr_count clears to 0.
- Outputs are decoded combinationally from the registered state plus opcode and zero. All outputs are 0 in INST_ADDR, so every output reads 0 during reset.
- Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Fixed cycle: INST_ADDR -> INST_FETCH -> INST_LOAD -> IDLE -> OP_ADDR -> OP_FETCH -> ALU_OP -> STORE -> INST_ADDR. Each state lasts exactly one clk cycle, so one instruction takes 8 cycles.
- Encodings: INST_ADDR=0 through STORE=7, HALTED=8. phase reflects the encoding.
- Per-state outputs (any output not listed is 0):
  - INST_ADDR: all outputs 0.
  - INST_FETCH: mem_rd=1.
  - INST_LOAD: mem_rd=1, load_ir=1.
  - IDLE: mem_rd=1, load_ir=1.
  - OP_ADDR: if opcode==HLT, halt=1, inc_pc=0, next state HALTED; otherwise inc_pc=1.
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP; inc_pc=(opcode==SKZ && zero); load_pc=(opcode==JMP).
  - STORE: mem_rd=ALUOP; load_ac=ALUOP; inc_pc=(opcode==JMP); load_pc=(opcode==JMP); mem_wr=(opcode==STO).
- HALTED: halt=1 and all other strobes 0. The state holds until reset; opcode and zero are ignored.
- zero is sampled only in ALU_OP. Changes to zero in other states have no effect.
- mem_rd and mem_wr are never both 1 in any state (STO is not an ALUOP).
- opcode is expected stable from IDLE through STORE. The outputs follow the opcode value present in each cycle; no latching is done.

Optional Feature:
- Macro SEQ_INSTR_COUNT_EN.
- Defined: instr_count increments by 1 on each STORE->INST_ADDR transition and saturates at all-ones (no wrap). HLT instructions are not counted.
- Undefined: instr_count is tied to 0 and no counter flops exist.

Test Plan:
- Reset release, opcode=ADD, zero=0 -> phase steps 0..7 then 0. mem_rd=1 in cycles 1-3 and 5-7. load_ir=1 in cycles 2-3. inc_pc=1 in cycle 4. load_ac=1 in cycle 7. mem_wr=0 throughout.
- opcode=STO, 8 cycles -> mem_wr=1 only in STORE. mem_rd=0 in OP_FETCH, ALU_OP and STORE. load_ac=0.
- opcode=SKZ with zero=1 -> inc_pc=1 in both OP_ADDR and ALU_OP. Repeat with zero=0 -> inc_pc=1 in OP_ADDR only.
- opcode=JMP -> load_pc=1 in ALU_OP and STORE; inc_pc=1 in OP_ADDR and STORE.
- opcode=HLT -> halt=1 from OP_ADDR onward and phase=8. phase and halt stay unchanged for 20 cycles with random opcode and zero. rst_n=0 returns phase=0 and halt=0 asynchronously, with no clk edge.
- Reset mid-instruction in ALU_OP -> phase=0 and all outputs 0 immediately. With SEQ_INSTR_COUNT_EN, CNT_W=2: after 5 non-HLT instructions instr_count=3 (saturated), and it reads 0 after reset.
